// File: rtl/blk_engine.sv
// blk_engine: autonomous sequencer for Z80 block instructions (LDxx/CPxx/INxx/OUTxx)
module blk_engine #(
  parameter int ADDR_W    = 16,
  parameter int IO_ADDR_W = 16,
  parameter int REP_GAP   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic                 dir_dec,
  input  logic                 rep,
  input  logic [ADDR_W-1:0]    hl_in,
  input  logic [ADDR_W-1:0]    de_in,
  input  logic [ADDR_W-1:0]    bc_in,
  input  logic [7:0]           a_in,
  input  logic [7:0]           flags_in,
  input  logic                 irq_pending,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata,
  input  logic                 mem_ack,
  output logic                 io_req,
  output logic                 io_we,
  output logic [IO_ADDR_W-1:0] io_addr,
  output logic [7:0]           io_wdata,
  input  logic [7:0]           io_rdata,
  input  logic                 io_ack,
  output logic [ADDR_W-1:0]    hl_out,
  output logic [ADDR_W-1:0]    de_out,
  output logic [ADDR_W-1:0]    bc_out,
  output logic [7:0]           flags_out,
  output logic                 busy,
  output logic                 done,
  output logic                 interrupted
);
  localparam logic [1:0] OP_LD = 2'd0, OP_CP = 2'd1, OP_IN = 2'd2, OP_OUT = 2'd3;
  localparam int GW = REP_GAP > 1 ? $clog2(REP_GAP) : 1;
  typedef enum logic [2:0] {IDLE, RD, WR, UPD, GAP, FIN} state_t;
  state_t state, state_nx;
  logic [7:0] a, d;
  logic [1:0] op_q;
  logic dir_q, rep_q;
  logic [GW-1:0] gap_cnt;
  logic tx_act, tx_io, tx_we, ack, h_cp, cont;
  logic [ADDR_W-1:0] tx_addr, hl_nx, de_nx, bc_bdec, bc_nx;
  logic [7:0] b_nx, c, cadj, n_ld, r_cp, n_cp, px, f_ld, f_cp, f_io, f_nx;
  logic [8:0] k;
  // iteration arithmetic: pointer/counter updates and the new flag byte for each op class
  always_comb begin
    hl_nx   = dir_q ? hl_out - ADDR_W'(1) : hl_out + ADDR_W'(1);
    de_nx   = dir_q ? de_out - ADDR_W'(1) : de_out + ADDR_W'(1);
    bc_bdec = bc_out - ADDR_W'(256);
    b_nx    = bc_bdec[15:8];
    c       = bc_out[7:0];
    cadj    = dir_q ? c - 8'd1 : c + 8'd1;
    n_ld    = d + a;
    r_cp    = a - d;
    h_cp    = a[3:0] < d[3:0];
    n_cp    = r_cp - {7'd0, h_cp};
    k       = {1'b0, d} + {1'b0, op_q == OP_IN ? cadj : hl_nx[7:0]};
    px      = {5'd0, k[2:0]} ^ b_nx;
    bc_nx   = op_q[1] ? bc_bdec : bc_out - ADDR_W'(1);
    f_ld    = {flags_out[7:6], n_ld[1], 1'b0, n_ld[3], bc_nx != '0, 1'b0, flags_out[0]};
    f_cp    = {r_cp[7], r_cp == 8'd0, n_cp[1], h_cp, n_cp[3], bc_nx != '0, 1'b1, flags_out[0]};
    f_io    = {b_nx[7], b_nx == 8'd0, b_nx[5], k[8], b_nx[3], ~^px, d[7], k[8]};
    f_nx    = op_q[1] ? f_io : op_q[0] ? f_cp : f_ld;
    cont    = op_q[1] ? ~f_io[6] : f_nx[2] & ~(op_q[0] & f_nx[6]);
  end
  // state register
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_nx;
  // next-state: walk read/write phases, then decide repeat, interrupt exit or finish
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RD;
      RD:      if (ack) state_nx = op_q == OP_CP ? UPD : WR;
      WR:      if (ack) state_nx = UPD;
      UPD:     state_nx = (!rep_q || !cont || irq_pending) ? FIN : REP_GAP == 0 ? RD : GAP;
      GAP:     if (gap_cnt == '0) state_nx = RD;
      default: state_nx = IDLE;
    endcase
  end
  // outputs: status flags and the transaction the current phase needs
  always_comb begin
    tx_act  = state == RD || state == WR;
    tx_io   = (state == RD && op_q == OP_IN) || (state == WR && op_q == OP_OUT);
    tx_we   = state == WR;
    tx_addr = state == WR ? (op_q == OP_LD ? de_out : op_q == OP_IN ? hl_out : bc_bdec)
                          : (op_q == OP_IN ? bc_out : hl_out);
    ack     = tx_io ? io_req & io_ack : mem_req & mem_ack;
    busy    = tx_act || state == UPD || state == GAP;
    done    = state == FIN;
  end
  // datapath: snapshot on start, one outstanding bus request at a time, register update in UPD
  always_ff @(posedge clk)
    if (reset) begin
      {mem_req, mem_we, mem_addr, mem_wdata} <= '0;
      {io_req, io_we, io_addr, io_wdata} <= '0;
      {hl_out, de_out, bc_out, flags_out, interrupted} <= '0;
      {a, d, op_q, dir_q, rep_q, gap_cnt} <= '0;
    end else begin
      if (state == IDLE && start) begin
        hl_out      <= hl_in;
        de_out      <= de_in;
        bc_out      <= bc_in;
        a           <= a_in;
        flags_out   <= flags_in;
        op_q        <= op;
        dir_q       <= dir_dec;
        rep_q       <= rep;
        interrupted <= 1'b0;
      end
      if (ack) begin
        mem_req <= 1'b0;
        io_req  <= 1'b0;
        if (state == RD) d <= tx_io ? io_rdata : mem_rdata;
      end else if (tx_act && !mem_req && !io_req) begin
        mem_req <= !tx_io;
        io_req  <= tx_io;
        if (tx_io) begin
          io_we    <= tx_we;
          io_addr  <= tx_addr[IO_ADDR_W-1:0];
          io_wdata <= d;
        end else begin
          mem_we    <= tx_we;
          mem_addr  <= tx_addr;
          mem_wdata <= d;
        end
      end
      if (state == UPD) begin
        hl_out      <= hl_nx;
        de_out      <= op_q == OP_LD ? de_nx : de_out;
        bc_out      <= bc_nx;
        flags_out   <= f_nx;
        interrupted <= rep_q & cont & irq_pending;
        gap_cnt     <= GW'(REP_GAP > 0 ? REP_GAP - 1 : 0);
      end
      if (state == GAP) gap_cnt <= gap_cnt - GW'(1);
    end
endmodule
